// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq
//  Purpose  : Bit-serial adder stage. Accepts two WIDTH-bit operands and a
//             carry-in over a valid/ready handshake, adds them LSB-first
//             through a single full-adder slice (one bit per clock) and
//             presents the WIDTH-bit sum and carry-out on a valid/ready
//             output handshake. Trades WIDTH cycles of latency for one slice.
//  Ports    :
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      operand set offered
//    in_ready   out  1      stage can accept an operand set (IDLE)
//    op_a       in   WIDTH  operand A
//    op_b       in   WIDTH  operand B
//    cin        in   1      carry into bit 0
//    out_valid  out  1      sum/cout valid and held (DONE)
//    out_ready  in   1      consumer accepts sum/cout
//    sum        out  WIDTH  (op_a + op_b + cin) mod 2^WIDTH
//    cout       out  1      carry out of bit WIDTH-1
//    busy       out  1      high while shifting
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Bit counter only has to reach WIDTH-1.
  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q,     a_d;      // operand A shift register
  logic [WIDTH-1:0] b_q,     b_d;      // operand B shift register
  logic [WIDTH-1:0] acc_q,   acc_d;    // partial sum, filled from the MSB end
  logic             carry_q, carry_d;  // carry flop between slices
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // bits processed so far
  logic [WIDTH-1:0] sum_q,   sum_d;    // published sum, held until next DONE
  logic             cout_q,  cout_d;   // published carry-out

  // Single full-adder slice operating on the current LSBs.
  logic slice_s;
  logic slice_c;

  always_comb begin
    slice_s = a_q[0] ^ b_q[0] ^ carry_q;
    slice_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Each new sum bit enters at the MSB; after WIDTH shifts bit 0 of
        // the result has migrated down to position 0.
        acc_d   = {slice_s, acc_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = slice_c;
        if (cnt_q == CNT_LAST) begin
          // Publish straight from the final slice so sum/cout only ever
          // change on entry to DONE.
          sum_d   = {slice_s, acc_q[WIDTH-1:1]};
          cout_d  = slice_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registered values or pure state decode, no input-to-output path
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_SHIFT);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_seq
//  Purpose  : Self-checking bench for serial_add_seq (WIDTH=8). Expected
//             results come from plain arithmetic on the offered operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

  localparam int W    = 8;
  localparam int NRND = 1000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact (W+1)-bit unsigned sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    ref_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait for the load, then wait for out_valid.
  // lat = edges after the load edge until out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output logic [W:0] res, output int lat, output bit ok);
    int guard;
    op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      step();
      lat++;
    end
    ok  = out_valid;
    res = {cout, sum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [W:0] res; int lat; bit ok;
    out_ready = 1'b1;
    run_op(8'h15, 8'h27, 1'b0, res, lat, ok);
    checks++;
    if (!ok || lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got ok=%0d lat=%0d, want lat=%0d", ok, lat, W);
    end
    checks++;
    if (res !== 9'h03C) begin
      errors++;
      $display("FAIL basic_result: got %h, want 03c", res);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handoff: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap();
    logic [W:0] res; int lat; bit ok;
    out_ready = 1'b1;
    run_op(8'hFF, 8'h01, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 9'h100) begin
      errors++;
      $display("FAIL wrap_ff_01: got ok=%0d res=%h, want 100", ok, res);
    end
    step();
    run_op(8'hFF, 8'hFF, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== 9'h1FF) begin
      errors++;
      $display("FAIL wrap_ff_ff_c1: got ok=%0d res=%h, want 1ff", ok, res);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    op_a = 8'h5A; op_b = 8'h33; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_output: got active_cycles=%0d rdy=%b, want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] res; int lat; bit ok; int bad;
    out_ready = 1'b0;
    run_op(8'hA5, 8'h6C, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== ref_add(8'hA5, 8'h6C, 1'b1)) begin
      errors++;
      $display("FAIL bp_result: got ok=%0d res=%h, want %h", ok, res, ref_add(8'hA5, 8'h6C, 1'b1));
    end
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || {cout, sum} !== res) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles, want 0 (vld=%b rdy=%b res=%h)", bad, out_valid,
               in_ready, {cout, sum});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0 || {cout, sum} !== res) begin
      errors++;
      $display("FAIL bp_ignored_offer: got busy=%b res=%h, want 0 %h", busy, {cout, sum}, res);
    end
  endtask

  task automatic test_input_hold();
    int guard;
    out_ready = 1'b1;
    op_a = 8'h3C; op_b = 8'h4D; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    op_a = 8'hC8; op_b = 8'h9E; cin = 1'b1; in_valid = 1'b1;
    guard = 0;
    while (!out_valid && guard < 4 * W) begin
      step();
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1 || {cout, sum} !== ref_add(8'h3C, 8'h4D, 1'b0)) begin
      errors++;
      $display("FAIL hold_first_result: got vld=%b res=%h, want 1 %h", out_valid, {cout, sum},
               ref_add(8'h3C, 8'h4D, 1'b0));
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle: got rdy=%b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_loaded: got busy=%b, want 1", busy);
    end
    guard = 0;
    while (!out_valid && guard < 4 * W) begin
      step();
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1 || {cout, sum} !== ref_add(8'hC8, 8'h9E, 1'b1)) begin
      errors++;
      $display("FAIL hold_second_result: got vld=%b res=%h, want 1 %h", out_valid, {cout, sum},
               ref_add(8'hC8, 8'h9E, 1'b1));
    end
    step();
  endtask

  task automatic test_random();
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    logic [W:0] held;
    logic [31:0] r;
    bit   stalled;
    bit   accept;
    int   sent, got, cyc, bad_res, bad_hold, empty_pops;
    sent = 0; got = 0; cyc = 0; bad_res = 0; bad_hold = 0; empty_pops = 0;
    stalled = 1'b0; held = '0;
    in_valid = 1'b0;
    while (got < NRND && cyc < 60000) begin
      // Output held stable while the previous cycle stalled it.
      if (stalled && (out_valid !== 1'b1 || {cout, sum} !== held)) bad_hold++;
      if (!in_valid && sent < NRND && $urandom_range(0, 3) != 0) begin
        r = $urandom;
        op_a = r[W-1:0];
        op_b = r[2*W-1:W];
        cin  = r[31];
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      accept = in_valid && in_ready;
      if (accept) begin
        exp_q.push_back(ref_add(op_a, op_b, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          empty_pops++;
        end else begin
          exp_v = exp_q.pop_front();
          if ({cout, sum} !== exp_v) begin
            bad_res++;
            if (bad_res <= 5)
              $display("FAIL rnd_result: got %h, want %h (result %0d)", {cout, sum}, exp_v, got);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {cout, sum};
      step();
      cyc++;
      if (accept) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (bad_res !== 0) begin
      errors++;
      $display("FAIL rnd_scoreboard: got %0d wrong results, want 0", bad_res);
    end
    checks++;
    if (bad_hold !== 0) begin
      errors++;
      $display("FAIL rnd_stall_hold: got %0d unstable cycles, want 0", bad_hold);
    end
    checks++;
    if (got !== NRND || sent !== NRND || exp_q.size() !== 0 || empty_pops !== 0) begin
      errors++;
      $display("FAIL rnd_count: got results=%0d sent=%0d pending=%0d extra=%0d, want %0d %0d 0 0",
               got, sent, exp_q.size(), empty_pops, NRND, NRND);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_reset_mid();
    test_backpressure();
    test_input_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
